rsa32_arb: RTL and testbench
============================

RSA32_ARB -- requirements
Module: rsa32_arb

Interface
REQ-001 SHALL have parameter: LAUNCH_TMO, 16, max cycles in LAUNCH waiting for i_eng_end to fall.
REQ-002 SHALL have ports (clock and reset first):
  i_clk  in  1  clock; all logic on rising edge
  i_rst  in  1  reset, synchronous, active-high
  i_req0_valid / i_req1_valid  in  1  requester k has an operation pending
  i_req0_base / i_req1_base  in  32  requester k base
  i_req0_exp / i_req1_exp  in  32  requester k exponent
  i_req0_N / i_req1_N  in  32  requester k modulus
  o_req0_ready / o_req1_ready  out  1  requester k operands accepted this cycle
  o_rsp0_valid / o_rsp1_valid  out  1  response to requester k pending
  o_rsp0_result / o_rsp1_result  out  32  (base^exp) mod N
  o_rsp0_err / o_rsp1_err  out  1  operation rejected or timed out
  i_rsp0_ready / i_rsp1_ready  in  1  requester k consumes response
  o_eng_start  out  1  level start to engine
  o_eng_base / o_eng_exp / o_eng_N  out  32  latched operands to engine
  i_eng_result  in  32  engine result
  i_eng_end  in  1  engine idle/done flag

Function
REQ-003 SHALL share one modexp engine between two requesters, one operation in flight.
REQ-004 SHALL use FSM states IDLE, LAUNCH, RUN, CAPTURE, RESP.
REQ-005 IDLE: while i_eng_end=1 and any valid, SHALL grant one requester and assert its o_reqk_ready combinationally for that cycle only; handshake = valid & ready.
REQ-006 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last; last-grant pointer resets to 1 (so req0 wins first tie).
REQ-007 On handshake SHALL latch base/exp/N into o_eng_* and record owner; o_eng_* SHALL hold until next handshake.
REQ-008 On handshake with N<2 SHALL skip the engine, set err=1, result=0, go to RESP.
REQ-009 Otherwise IDLE->LAUNCH; LAUNCH drives o_eng_start=1 and counts cycles.
REQ-010 LAUNCH: i_eng_end=0 -> RUN with o_eng_start=0; counter reaching LAUNCH_TMO with i_eng_end still 1 -> err=1, result=0, RESP.
REQ-011 RUN: o_eng_start=0; i_eng_end=1 -> CAPTURE; no timeout in RUN.
REQ-012 CAPTURE (one cycle): SHALL latch i_eng_result into the owner's result, err=0, go to RESP.
REQ-013 RESP: owner's o_rspk_valid=1 with stable result/err until i_rspk_ready=1; then valid drops next cycle, state->IDLE.
REQ-014 o_eng_start SHALL be 0 in every state except LAUNCH, giving at least one low cycle between launches.
REQ-015 Requests arriving outside IDLE or while i_eng_end=0 SHALL see ready=0 and wait; no request is dropped.
REQ-016 Non-owner o_rsp*_valid SHALL stay 0; at most one rsp valid at a time.
REQ-017 exp=0 SHALL pass to engine unchanged; expected result 1 mod N.

Reset
REQ-018 i_rst=1 at any edge SHALL force IDLE, o_eng_start=0, o_req*_ready=0, o_rsp*_valid=0, o_rsp*_result=0, o_rsp*_err=0, o_eng_*=0, timeout counter=0, last-grant=1.
REQ-019 Reset mid-operation SHALL abandon the in-flight operation without response; first post-reset grant waits for i_eng_end=1.

Verification
REQ-020 req0 only, base=4, exp=13, N=497 -> ready0 one cycle, start pulse, rsp0_valid with result=445, err=0.
REQ-021 req0 and req1 valid same cycle, both base=2, exp=10, N=1000 -> req0 served first (result 24), then req1 (result 24); third simultaneous tie -> req0.
REQ-022 req1 with N=1 -> no o_eng_start, rsp1_valid err=1 result=0 within 2 cycles of handshake.
REQ-023 engine model holds i_eng_end=1 -> err=1 result=0 after 16 LAUNCH cycles, o_eng_start back to 0.
REQ-024 i_rsp0_ready held 0 for 5 cycles during RESP -> result/err stable, req1 not granted until release.
REQ-025 i_rst=1 during RUN -> all outputs at reset values next cycle; new request after engine idle completes correctly.

Source files
------------

// File: rtl/rsa32_arb.sv
// Round-robin arbiter sharing one modular-exponentiation engine between two
// requesters; one operation in flight, launch watchdog, per-requester response.
module rsa32_arb #(
  parameter int LAUNCH_TMO = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  input  logic [31:0] i_req0_base,
  input  logic [31:0] i_req0_exp,
  input  logic [31:0] i_req0_N,
  output logic        o_req0_ready,
  input  logic        i_req1_valid,
  input  logic [31:0] i_req1_base,
  input  logic [31:0] i_req1_exp,
  input  logic [31:0] i_req1_N,
  output logic        o_req1_ready,
  output logic        o_rsp0_valid,
  output logic [31:0] o_rsp0_result,
  output logic        o_rsp0_err,
  input  logic        i_rsp0_ready,
  output logic        o_rsp1_valid,
  output logic [31:0] o_rsp1_result,
  output logic        o_rsp1_err,
  input  logic        i_rsp1_ready,
  output logic        o_eng_start,
  output logic [31:0] o_eng_base,
  output logic [31:0] o_eng_exp,
  output logic [31:0] o_eng_N,
  input  logic [31:0] i_eng_result,
  input  logic        i_eng_end
);

  localparam int CW = $clog2(LAUNCH_TMO + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, CAPTURE, RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_owner;
  logic          r_last;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_eng_base;
  logic [31:0]   r_eng_exp;
  logic [31:0]   r_eng_N;
  logic [31:0]   r_res0;
  logic [31:0]   r_res1;
  logic          r_err0;
  logic          r_err1;

  logic          w_grant_ok;
  logic          w_pick1;
  logic          w_bad_mod;
  logic          w_tmo;
  logic          w_rsp_take;
  logic          w_wr;
  logic          w_wr_sel;
  logic [31:0]   w_wr_res;
  logic          w_wr_err;

  // Ready goes only to a valid requester, so a grant is always a handshake.
  assign w_grant_ok = (r_state == IDLE) && i_eng_end && !i_rst &&
                      (i_req0_valid || i_req1_valid);
  assign w_pick1    = i_req1_valid && (!i_req0_valid || !r_last);
  assign w_bad_mod  = w_pick1 ? (i_req1_N < 32'd2) : (i_req0_N < 32'd2);
  assign w_tmo      = (r_cnt == CW'(LAUNCH_TMO - 1));
  assign w_rsp_take = r_owner ? i_rsp1_ready : i_rsp0_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_grant_ok) w_next = w_bad_mod ? RESP : LAUNCH;
      LAUNCH:  if (!i_eng_end) w_next = RUN;
               else if (w_tmo) w_next = RESP;
      RUN:     if (i_eng_end) w_next = CAPTURE;
      CAPTURE: w_next = RESP;
      RESP:    if (w_rsp_take) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    o_req0_ready = w_grant_ok && !w_pick1;
    o_req1_ready = w_grant_ok && w_pick1;
    o_eng_start  = (r_state == LAUNCH);
    o_rsp0_valid = (r_state == RESP) && !r_owner;
    o_rsp1_valid = (r_state == RESP) && r_owner;
  end

  // Response-register write: rejected modulus, launch timeout, or engine capture.
  always_comb begin
    w_wr     = 1'b0;
    w_wr_sel = r_owner;
    w_wr_res = '0;
    w_wr_err = 1'b1;
    case (r_state)
      IDLE: if (w_grant_ok && w_bad_mod) begin
        w_wr     = 1'b1;
        w_wr_sel = w_pick1;
      end
      LAUNCH: if (i_eng_end && w_tmo) w_wr = 1'b1;
      CAPTURE: begin
        w_wr     = 1'b1;
        w_wr_res = i_eng_result;
        w_wr_err = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_cnt      <= '0;
      r_eng_base <= '0;
      r_eng_exp  <= '0;
      r_eng_N    <= '0;
      r_res0     <= '0;
      r_res1     <= '0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
    end else begin
      if (w_grant_ok) begin
        r_owner    <= w_pick1;
        r_last     <= w_pick1;
        r_cnt      <= '0;
        r_eng_base <= w_pick1 ? i_req1_base : i_req0_base;
        r_eng_exp  <= w_pick1 ? i_req1_exp  : i_req0_exp;
        r_eng_N    <= w_pick1 ? i_req1_N    : i_req0_N;
      end else if ((r_state == LAUNCH) && i_eng_end && !w_tmo) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_wr) begin
        if (w_wr_sel) begin
          r_res1 <= w_wr_res;
          r_err1 <= w_wr_err;
        end else begin
          r_res0 <= w_wr_res;
          r_err0 <= w_wr_err;
        end
      end
    end
  end

  assign o_eng_base    = r_eng_base;
  assign o_eng_exp     = r_eng_exp;
  assign o_eng_N       = r_eng_N;
  assign o_rsp0_result = r_res0;
  assign o_rsp0_err    = r_err0;
  assign o_rsp1_result = r_res1;
  assign o_rsp1_err    = r_err1;

endmodule

// File: tb/tb_rsa32_arb.sv
// Bench for rsa32_arb: directed scenarios plus randomized traffic, scored
// against a transaction-level model (round-robin rule + modexp arithmetic).
module tb_rsa32_arb;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, rdy0, rdy1, rv0, rv1, re0, re1, rr0, rr1;
  logic [31:0] b0, e0, n0, b1, e1, n1, res0, res1;
  logic        eng_start, eng_end;
  logic [31:0] eb, ee, en, eng_res;

  always #5 clk = ~clk;

  rsa32_arb #(.LAUNCH_TMO(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0), .i_req0_base(b0), .i_req0_exp(e0), .i_req0_N(n0), .o_req0_ready(rdy0),
    .i_req1_valid(v1), .i_req1_base(b1), .i_req1_exp(e1), .i_req1_N(n1), .o_req1_ready(rdy1),
    .o_rsp0_valid(rv0), .o_rsp0_result(res0), .o_rsp0_err(re0), .i_rsp0_ready(rr0),
    .o_rsp1_valid(rv1), .o_rsp1_result(res1), .o_rsp1_err(re1), .i_rsp1_ready(rr1),
    .o_eng_start(eng_start), .o_eng_base(eb), .o_eng_exp(ee), .o_eng_N(en),
    .i_eng_result(eng_res), .i_eng_end(eng_end)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e,
                                         input logic [31:0] n);
    logic [63:0] r, x, m;
    if (n < 32'd2) return '0;
    m = {32'd0, n};
    r = 64'd1;
    x = {32'd0, b} % m;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % m;
      x = (x * x) % m;
    end
    return r[31:0];
  endfunction

  // Environment knobs
  logic rnd_rdy = 1'b0, eng_stuck = 1'b0, eng_slow = 1'b0;

  // Engine model: drops end a few cycles after start, computes, raises end.
  initial begin
    eng_end = 1'b1;
    eng_res = '0;
    forever begin
      @(negedge clk);
      if (eng_start && eng_end && !eng_stuck) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 eng_end = 1'b0;
        repeat (eng_slow ? 10 : $urandom_range(1, 5)) @(posedge clk);
        #1 eng_res = modexp(eb, ee, en);
        eng_end = 1'b1;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      rr0 = ($urandom_range(0, 3) != 0);
      rr1 = ($urandom_range(0, 3) != 0);
    end
  end

  // Transaction model / scoreboard
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        busy = 1'b0, m_last = 1'b1, own = 1'b0, x_err = 1'b0, rsp_seen = 1'b0;
  logic [31:0] x_res = '0;
  logic        hold = 1'b0, hold_err = 1'b0, le = 1'b0, ls = 1'b0;
  logic [31:0] hold_res = '0, lr = '0;
  int          hs_cyc = 0, rsp_lat = 0, n_rdy0 = 0, n_rdy1 = 0, n_start = 0;
  int          gq[$];
  logic        k, own_r, own_err;
  logic [31:0] mb, me, mn, own_res;

  always @(negedge clk) begin
    if (rst) begin
      busy = 1'b0;
      m_last = 1'b1;
      hold = 1'b0;
    end else begin
      if (rdy0) n_rdy0++;
      if (rdy1) n_rdy1++;
      if (eng_start) n_start++;
      if (rv0 || rv1) begin
        own_r   = own ? rr1 : rr0;
        own_res = own ? res1 : res0;
        own_err = own ? re1 : re0;
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          rsp_lat = cyc - hs_cyc;
          check_eq("rsp_pending", busy, 1);
          check_eq("rsp_owner_onehot", {rv1, rv0}, own ? 2'b10 : 2'b01);
        end
        if (hold) check_eq("rsp_stable", {own_err, own_res}, {hold_err, hold_res});
        hold = !own_r;
        hold_res = own_res;
        hold_err = own_err;
        if (own_r) begin
          check_eq(own ? "rsp1_result" : "rsp0_result", own_res, x_res);
          check_eq(own ? "rsp1_err" : "rsp0_err", own_err, x_err);
          lr = own_res;
          le = own_err;
          ls = eng_start;
          busy = 1'b0;
        end
      end else if (hold) begin
        check_eq("rsp_held_valid", rv0 | rv1, 1);
        hold = 1'b0;
      end
      if ((v0 && rdy0) || (v1 && rdy1)) begin
        k = v1 && rdy1;
        check_eq("grant_exclusive", rdy0 & rdy1, 0);
        check_eq("grant_when_free", busy, 0);
        check_eq("grant_eng_idle", eng_end, 1);
        if (v0 && v1) check_eq("rr_winner", k, !m_last);
        mb = k ? b1 : b0;
        me = k ? e1 : e0;
        mn = k ? n1 : n0;
        x_err = (mn < 32'd2) || eng_stuck;
        x_res = x_err ? 32'd0 : modexp(mb, me, mn);
        own = k;
        m_last = k;
        busy = 1'b1;
        rsp_seen = 1'b0;
        hs_cyc = cyc;
        gq.push_back(int'(k));
      end
    end
  end

  task automatic issue(input int kk, input logic [31:0] b, input logic [31:0] e,
                       input logic [31:0] n);
    logic got = 1'b0;
    if (kk == 0) begin v0 = 1'b1; b0 = b; e0 = e; n0 = n; end
    else         begin v1 = 1'b1; b1 = b; e1 = e; n1 = n; end
    for (int t = 0; t < 500 && !got; t++) begin
      @(negedge clk);
      got = (kk == 0) ? (v0 && rdy0) : (v1 && rdy1);
    end
    check_eq("handshake_in_time", got, 1);
    @(posedge clk);
    #1;
    if (kk == 0) v0 = 1'b0;
    else         v1 = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy && t < budget) begin
      @(negedge clk);
      t++;
    end
    check_eq("response_in_time", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, {rdy1, rdy0}, 0);
    check_eq({tag, "_start"}, eng_start, 0);
    check_eq({tag, "_rsp_valid"}, {rv1, rv0}, 0);
    check_eq({tag, "_rsp_err"}, {re1, re0}, 0);
    check_eq({tag, "_results"}, {res1, res0}, 0);
    check_eq({tag, "_eng_base"}, eb, 0);
    check_eq({tag, "_eng_exp_n"}, {ee, en}, 0);
  endtask

  task automatic rand_op(input int kk);
    logic [31:0] b, e, n;
    b = $urandom;
    e = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
    case ($urandom_range(0, 7))
      0:       n = $urandom_range(0, 1);
      1:       n = 32'd2;
      default: n = $urandom;
    endcase
    issue(kk, b, e, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    v0 = 1'b1; v1 = 1'b1;
    b0 = '0; e0 = '0; n0 = '0; b1 = '0; e1 = '0; n1 = '0;
    rr0 = 1'b1; rr1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    v0 = 1'b0; v1 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request, engine path
    n_rdy0 = 0; n_start = 0;
    issue(0, 32'd4, 32'd13, 32'd497);
    wait_idle(200);
    check_eq("t20_ready_cycles", n_rdy0, 1);
    check_eq("t20_start_seen", n_start > 0, 1);
    check_eq("t20_result", lr, 445);
    check_eq("t20_err", le, 0);

    // Ties after reset: req0, req1, then req0 again
    do_reset();
    gq.delete();
    fork
      issue(0, 32'd2, 32'd10, 32'd1000);
      issue(1, 32'd2, 32'd10, 32'd1000);
    join
    wait_idle(200);
    check_eq("t21_grants", gq.size(), 2);
    if (gq.size() >= 2) check_eq("t21_order", {gq[0][0], gq[1][0]}, 2'b01);
    check_eq("t21_result", lr, 24);
    gq.delete();
    fork
      issue(0, 32'd2, 32'd10, 32'd1000);
      issue(1, 32'd2, 32'd10, 32'd1000);
    join
    wait_idle(200);
    check_eq("t21_third_tie_grants", gq.size(), 2);
    if (gq.size() >= 1) check_eq("t21_third_tie", gq[0], 0);

    // Rejected modulus bypasses the engine
    n_start = 0;
    issue(1, 32'd7, 32'd5, 32'd1);
    wait_idle(50);
    check_eq("t22_no_start", n_start, 0);
    check_eq("t22_err", le, 1);
    check_eq("t22_result", lr, 0);
    check_eq("t22_latency", rsp_lat <= 2, 1);

    // Engine never leaves idle: launch timeout
    eng_stuck = 1'b1;
    n_start = 0;
    issue(0, 32'd4, 32'd13, 32'd497);
    wait_idle(200);
    check_eq("t23_launch_cycles", n_start, TMO);
    check_eq("t23_err", le, 1);
    check_eq("t23_result", lr, 0);
    check_eq("t23_start_low", ls, 0);
    eng_stuck = 1'b0;

    // Response back-pressure blocks the other requester
    rr0 = 1'b0;
    issue(0, 32'd3, 32'd7, 32'd1000);
    fork
      issue(1, 32'd5, 32'd3, 32'd77);
      begin
        for (int t = 0; t < 200 && !rv0; t++) @(negedge clk);
        check_eq("t24_rsp0_up", rv0, 1);
        repeat (5) begin
          @(negedge clk);
          check_eq("t24_req1_blocked", rdy1, 0);
          check_eq("t24_rsp0_held", rv0, 1);
        end
        @(posedge clk);
        #1 rr0 = 1'b1;
      end
    join
    wait_idle(200);
    check_eq("t24_req1_result", lr, 48);

    // Reset while the engine is running
    eng_slow = 1'b1;
    issue(0, 32'd9, 32'd11, 32'd1009);
    for (int t = 0; t < 50 && eng_end; t++) @(negedge clk);
    check_eq("t25_engine_busy", eng_end, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("t25_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    eng_slow = 1'b0;
    issue(1, 32'd6, 32'd0, 32'd35);
    wait_idle(200);
    check_eq("t25_exp0_result", lr, 1);
    check_eq("t25_err", le, 0);

    // Randomized traffic
    rnd_rdy = 1'b1;
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        rand_op(0);
      end
      for (int j = 0; j < 25; j++) begin
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        rand_op(1);
      end
    join
    wait_idle(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
